// File: rtl/gs_lsu_pipe_if.sv
// Request/memory/response bundle for gs_lsu_pipe; slave = LSU side, master = requester/memory side.
interface gs_lsu_pipe_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int NB = DATA_W / 8;

  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_we_i;
  logic [2:0]        req_size_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [DATA_W-1:0] req_wdata_i;
  logic              mem_oe_o;
  logic [NB-1:0]     mem_web_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic [DATA_W-1:0] mem_data_i;
  logic              resp_valid_o;
  logic              resp_ready_i;
  logic [DATA_W-1:0] resp_rdata_o;
  logic              resp_err_o;
  logic              busy_o;

  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_addr_i, req_wdata_i, mem_data_i, resp_ready_i,
    output req_ready_o, mem_oe_o, mem_web_o, mem_addr_o, mem_data_o, resp_valid_o, resp_rdata_o,
           resp_err_o, busy_o
  );

  modport master (
    output req_valid_i, req_we_i, req_size_i, req_addr_i, req_wdata_i, mem_data_i, resp_ready_i,
    input  req_ready_o, mem_oe_o, mem_web_o, mem_addr_o, mem_data_o, resp_valid_o, resp_rdata_o,
           resp_err_o, busy_o
  );
endinterface

// File: rtl/gs_lsu_pipe.sv
// Single-outstanding load/store unit: lane steering for stores, shift + extension for loads.
// Define GS_LSU_MISALIGN_TRAP_EN to reject misaligned accesses instead of force-aligning them.
module gs_lsu_pipe #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input logic          clk,
  input logic          rst,
  gs_lsu_pipe_if.slave bus
);
  localparam int NB   = DATA_W / 8;
  localparam int OFFW = $clog2(NB);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            r_state, w_next;
  logic              r_we;
  logic [2:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic [3:0]        r_cnt;

  logic              w_illegal, w_trap, w_bad;
  logic [OFFW-1:0]   w_off;
  logic [NB-1:0]     w_bmask;
  logic [DATA_W-1:0] w_shift, w_tmp, w_ext;
  int                w_width;

  // Low offset bits that must be zero for the natural alignment of a size code.
  function automatic logic [OFFW-1:0] align_mask(input logic [1:0] sz);
    logic [OFFW-1:0] m;
    m = '0;
    for (int k = 0; k < OFFW; k++) m[k] = (k < int'(sz));
    return m;
  endfunction

  assign w_illegal = (bus.req_size_i == 3'b111) ||
                     ((DATA_W == 32) && ((bus.req_size_i == 3'b011) || (bus.req_size_i == 3'b110)));

`ifdef GS_LSU_MISALIGN_TRAP_EN
  assign w_trap = |(bus.req_addr_i[OFFW-1:0] & align_mask(bus.req_size_i[1:0]));
  assign w_off  = r_addr[OFFW-1:0];
`else
  assign w_trap = 1'b0;
  assign w_off  = r_addr[OFFW-1:0] & ~align_mask(r_size[1:0]);
`endif

  assign w_bad = w_illegal | w_trap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Rejected requests bypass ISSUE so the memory never sees them.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.req_valid_i) w_next = w_bad ? RESP : ISSUE;
      ISSUE:   w_next = r_we ? RESP : WAIT;
      WAIT:    if (r_cnt == 4'd0) w_next = RESP;
      RESP:    if (bus.resp_ready_i) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we    <= 1'b0;
      r_size  <= 3'b000;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        IDLE: if (bus.req_valid_i) begin
          r_we    <= bus.req_we_i;
          r_size  <= bus.req_size_i;
          r_addr  <= bus.req_addr_i;
          r_wdata <= bus.req_wdata_i;
          r_err   <= w_bad;
          r_rdata <= '0;
        end
        ISSUE: r_cnt <= 4'(MEM_LAT - 1);
        WAIT: begin
          if (r_cnt == 4'd0) r_rdata <= w_ext;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (r_size[1:0])
      2'd0:    w_bmask = NB'(1);
      2'd1:    w_bmask = NB'(3);
      2'd2:    w_bmask = NB'(15);
      default: w_bmask = '1;
    endcase
  end

  // Align the addressed item to bit 0, then sign/zero extend by pushing it to the top and back.
  always_comb begin
    case (r_size[1:0])
      2'd0:    w_width = 8;
      2'd1:    w_width = 16;
      2'd2:    w_width = 32;
      default: w_width = DATA_W;
    endcase
    w_shift = bus.mem_data_i >> {w_off, 3'b000};
    w_tmp   = w_shift << (DATA_W - w_width);
    if (r_size[2]) w_ext = w_tmp >> (DATA_W - w_width);
    else           w_ext = $signed(w_tmp) >>> (DATA_W - w_width);
  end

  always_comb begin
    bus.req_ready_o  = (r_state == IDLE);
    bus.busy_o       = (r_state != IDLE);
    bus.mem_oe_o     = 1'b0;
    bus.mem_web_o    = '0;
    bus.mem_addr_o   = '0;
    bus.mem_data_o   = '0;
    bus.resp_valid_o = 1'b0;
    bus.resp_rdata_o = '0;
    bus.resp_err_o   = 1'b0;
    case (r_state)
      ISSUE: begin
        bus.mem_oe_o   = ~r_we;
        bus.mem_addr_o = {r_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
        if (r_we) begin
          bus.mem_web_o  = w_bmask << w_off;
          bus.mem_data_o = r_wdata << {w_off, 3'b000};
        end
      end
      RESP: begin
        bus.resp_valid_o = 1'b1;
        bus.resp_rdata_o = r_rdata;
        bus.resp_err_o   = r_err;
      end
      default: ;
    endcase
  end
endmodule
